// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step sequencer: divides clk into a pipeline enable strobe and gates fetch so halts drain cleanly.
// Optional feature macro: PIPE_PERF_CNT_EN builds the issued-instruction counter behind issue_cnt.
module pipe_run_ctrl #(
    parameter int unsigned DIV_MAX   = 50,
    parameter int unsigned DRAIN_TKS = 4,
    parameter bit          START_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_if,
    output logic        pipe_en,
    output logic        fetch_hold,
    output logic        halted,
    output logic        step_done,
    output logic        bp_hit,
    output logic [1:0]  state,
    output logic [31:0] issue_cnt
);

    typedef enum logic [1:0] {
        ST_HALTED = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_DRAIN  = 2'b11
    } run_state_t;

    localparam int unsigned   DW          = (DRAIN_TKS > 1) ? $clog2(DRAIN_TKS) : 1;
    localparam logic [23:0]   DIV_LAST    = 24'(DIV_MAX);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TKS - 1);
    localparam logic [DW-1:0] DRAIN_ONE   = DW'(1);
    localparam run_state_t    RESET_STATE = START_RUN ? ST_RUN : ST_HALTED;

    logic [23:0]   div_cnt_r;
    run_state_t    state_r;
    logic [DW-1:0] drain_cnt_r;
    logic          step_prev_r;
    logic          step_pend_r;
    logic          bp_skip_r;
    logic          step_done_r;
    logic          bp_hit_r;

    logic          tick_s;
    logic [23:0]   div_cnt_nxt_s;
    logic          bp_match_s;
    logic          step_rise_s;
    logic          step_pend_s;
    logic          pipe_en_s;
    logic          fetch_hold_s;
    run_state_t    state_nxt_s;
    logic [DW-1:0] drain_nxt_s;
    logic          pend_nxt_s;
    logic          skip_nxt_s;
    logic          done_nxt_s;
    logic          hit_nxt_s;
    logic          unused_lsb_s;

    // Word-aligned PCs: the byte-offset bits never take part in the breakpoint compare.
    assign unused_lsb_s  = ^{bp_addr[1:0], pc_if[1:0]};

    assign tick_s        = (div_cnt_r == DIV_LAST);
    assign div_cnt_nxt_s = tick_s ? 24'd0 : (div_cnt_r + 24'd1);
    assign bp_match_s    = bp_en & (pc_if[31:2] == bp_addr[31:2]) & ~bp_skip_r;
    assign step_rise_s   = step_req & ~step_prev_r;
    assign step_pend_s   = step_pend_r | step_rise_s;
    assign pipe_en_s     = tick_s & (state_r != ST_HALTED);

    // Next-state, fetch gating and sticky-flag updates; transitions only on a tick.
    always_comb begin
        state_nxt_s  = state_r;
        drain_nxt_s  = drain_cnt_r;
        pend_nxt_s   = step_pend_s;
        skip_nxt_s   = bp_skip_r;
        done_nxt_s   = 1'b0;
        hit_nxt_s    = bp_hit_r;
        fetch_hold_s = 1'b1;
        case (state_r)
            ST_HALTED: begin
                fetch_hold_s = 1'b1;
                if (tick_s) begin
                    if (halt_req) begin
                        state_nxt_s = ST_HALTED;
                    end else if (run_req) begin
                        state_nxt_s = ST_RUN;
                        skip_nxt_s  = 1'b1;
                        hit_nxt_s   = 1'b0;
                    end else if (step_pend_s) begin
                        state_nxt_s = ST_STEP;
                        pend_nxt_s  = 1'b0;
                        hit_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = ST_HALTED;
                    end
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_RUN: begin
                fetch_hold_s = bp_match_s;
                if (tick_s) begin
                    skip_nxt_s = 1'b0;
                    if (halt_req || bp_match_s) begin
                        state_nxt_s = ST_DRAIN;
                        drain_nxt_s = '0;
                        hit_nxt_s   = bp_hit_r | bp_match_s;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STEP: begin
                fetch_hold_s = 1'b0;
                if (tick_s) begin
                    state_nxt_s = ST_DRAIN;
                    drain_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_DRAIN: begin
                fetch_hold_s = 1'b1;
                if (tick_s) begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_nxt_s = ST_HALTED;
                        done_nxt_s  = 1'b1;
                    end else begin
                        drain_nxt_s = drain_cnt_r + DRAIN_ONE;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s  = RESET_STATE;
                fetch_hold_s = 1'b1;
            end
        endcase
    end

    // Sequencer state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_r   <= 24'd0;
            state_r     <= RESET_STATE;
            drain_cnt_r <= '0;
            step_prev_r <= 1'b0;
            step_pend_r <= 1'b0;
            bp_skip_r   <= 1'b1;
            step_done_r <= 1'b0;
            bp_hit_r    <= 1'b0;
        end else begin
            div_cnt_r   <= div_cnt_nxt_s;
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_nxt_s;
            step_prev_r <= step_req;
            step_pend_r <= pend_nxt_s;
            bp_skip_r   <= skip_nxt_s;
            step_done_r <= done_nxt_s;
            bp_hit_r    <= hit_nxt_s;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] issue_cnt_r;

    // Counts ticks on which a new instruction was actually fetched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt_r <= 32'd0;
        end else if (pipe_en_s && !fetch_hold_s) begin
            issue_cnt_r <= issue_cnt_r + 32'd1;
        end else begin
            issue_cnt_r <= issue_cnt_r;
        end
    end

    assign issue_cnt = issue_cnt_r;
`else
    assign issue_cnt = 32'h0;
`endif

    assign pipe_en    = pipe_en_s;
    assign fetch_hold = fetch_hold_s;
    assign halted     = (state_r == ST_HALTED);
    assign step_done  = step_done_r;
    assign bp_hit     = bp_hit_r;
    assign state      = state_r;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: main instance DIV_MAX=3/DRAIN_TKS=4/START_RUN=1, second instance DIV_MAX=0/START_RUN=0.
module tb_pipe_run_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        run_req, halt_req, step_req, bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        pipe_en, fetch_hold, halted, step_done, bp_hit;
    logic [1:0]  state;
    logic [31:0] issue_cnt;

    logic        run_req0;
    logic        pipe_en0, fetch_hold0, halted0, step_done0, bp_hit0;
    logic [1:0]  state0;
    logic [31:0] issue_cnt0;

    logic        pc_load_en;
    logic [31:0] pc_load_val;

    int n_cmp;
    int n_fail;

    pipe_run_ctrl #(.DIV_MAX(3), .DRAIN_TKS(4), .START_RUN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc_if(pc),
        .pipe_en(pipe_en), .fetch_hold(fetch_hold), .halted(halted),
        .step_done(step_done), .bp_hit(bp_hit), .state(state), .issue_cnt(issue_cnt)
    );

    pipe_run_ctrl #(.DIV_MAX(0), .DRAIN_TKS(4), .START_RUN(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .run_req(run_req0), .halt_req(1'b0),
        .step_req(1'b0), .bp_en(1'b0), .bp_addr(32'h0), .pc_if(32'h0),
        .pipe_en(pipe_en0), .fetch_hold(fetch_hold0), .halted(halted0),
        .step_done(step_done0), .bp_hit(bp_hit0), .state(state0), .issue_cnt(issue_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the CPU PC register: advances only on an enabled, unheld fetch.
    always @(posedge clk) begin
        if (pc_load_en) pc <= pc_load_val;
        else if (pipe_en && !fetch_hold) pc <= pc + 32'd4;
    end

    task automatic wait_pipe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pipe_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (state == want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL rst_state: got %b want 01", state); end
        n_cmp++; if ({pipe_en, fetch_hold, halted, step_done, bp_hit} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_flags: got %b want 00000", {pipe_en, fetch_hold, halted, step_done, bp_hit}); end
        n_cmp++; if (issue_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_issue: got %0d want 0", issue_cnt); end
        n_cmp++; if ({state0, halted0, fetch_hold0, pipe_en0} !== 5'b00110) begin
            n_fail++; $display("FAIL rst_dut0: got %b want 00110", {state0, halted0, fetch_hold0, pipe_en0}); end
    endtask

    task automatic test_tick_phase(input string tag);
        logic exp_pe;
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_pe = ((k % 4) == 3);
            n_cmp++; if (pipe_en !== exp_pe || fetch_hold !== 1'b0 || state !== 2'b01 || step_done !== 1'b0) begin
                n_fail++; $display("FAIL %s_clk%0d: pe/fh/st/sd got %b/%b/%b/%b want %b/0/01/0",
                                   tag, k, pipe_en, fetch_hold, state, step_done, exp_pe); end
        end
        n_cmp++; if (issue_cnt !== (PERF ? 32'd3 : 32'd0)) begin
            n_fail++; $display("FAIL %s_issue: got %0d want %0d", tag, issue_cnt, PERF ? 3 : 0); end
    endtask

    task automatic drain_and_halt(input string tag);
        bit ok;
        for (int t = 0; t < 4; t++) begin
            wait_pipe(ok);
            n_cmp++; if (!ok || state !== 2'b11 || fetch_hold !== 1'b1) begin
                n_fail++; $display("FAIL %s_drain%0d: tick/st/fh got %b/%b/%b want 1/11/1", tag, t, ok, state, fetch_hold); end
        end
        @(negedge clk);
        n_cmp++; if (state !== 2'b00 || halted !== 1'b1 || step_done !== 1'b1) begin
            n_fail++; $display("FAIL %s_halt: st/hl/sd got %b/%b/%b want 00/1/1", tag, state, halted, step_done); end
        @(negedge clk);
        n_cmp++; if (step_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: got %b want 0", tag, step_done); end
    endtask

    task automatic test_halt;
        bit ok;
        halt_req = 1'b1;
        wait_pipe(ok);
        n_cmp++; if (!ok || state !== 2'b01) begin n_fail++; $display("FAIL halt_tick: tick/st got %b/%b want 1/01", ok, state); end
        @(negedge clk);
        halt_req = 1'b0;
        n_cmp++; if (state !== 2'b11 || fetch_hold !== 1'b1) begin
            n_fail++; $display("FAIL halt_enter: st/fh got %b/%b want 11/1", state, fetch_hold); end
        drain_and_halt("halt");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (pipe_en !== 1'b0) begin n_fail++; $display("FAIL halt_quiet%0d: pipe_en got %b want 0", k, pipe_en); end
        end
        n_cmp++; if (issue_cnt !== (PERF ? 32'd4 : 32'd0)) begin
            n_fail++; $display("FAIL halt_issue: got %0d want %0d", issue_cnt, PERF ? 4 : 0); end
    endtask

    task automatic test_halt_priority;
        halt_req = 1'b1;
        run_req  = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (state !== 2'b00 || halted !== 1'b1) begin
            n_fail++; $display("FAIL prio_halted: st/hl got %b/%b want 00/1", state, halted); end
        halt_req = 1'b0;
        run_req  = 1'b0;
    endtask

    task automatic test_step;
        bit ok;
        step_req = 1'b1;
        wait_state(2'b10, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL step_enter: st got %b want 10", state); end
        step_req = 1'b0;
        wait_pipe(ok);
        n_cmp++; if (!ok || state !== 2'b10 || fetch_hold !== 1'b0) begin
            n_fail++; $display("FAIL step_fetch: tick/st/fh got %b/%b/%b want 1/10/0", ok, state, fetch_hold); end
        @(negedge clk);
        n_cmp++; if (state !== 2'b11) begin n_fail++; $display("FAIL step_drain: st got %b want 11", state); end
        drain_and_halt("step");
        n_cmp++; if (issue_cnt !== (PERF ? 32'd5 : 32'd0)) begin
            n_fail++; $display("FAIL step_issue: got %0d want %0d", issue_cnt, PERF ? 5 : 0); end
    endtask

    task automatic test_breakpoint;
        bit ok;
        bit seen;
        int fetched;
        pc_load_val = 32'h0040_0000;
        pc_load_en  = 1'b1;
        @(negedge clk);
        pc_load_en  = 1'b0;
        bp_en       = 1'b1;
        bp_addr     = 32'h0040_0013;
        run_req     = 1'b1;
        wait_state(2'b01, ok);
        run_req     = 1'b0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_run: st got %b want 01", state); end
        fetched = 0;
        seen    = 1'b0;
        for (int t = 0; t < 8; t++) begin
            wait_pipe(ok);
            if (!ok) break;
            if (pc == 32'h0040_0010) begin
                seen = 1'b1;
                n_cmp++; if (fetch_hold !== 1'b1) begin n_fail++; $display("FAIL bp_hold: fh got %b want 1", fetch_hold); end
                break;
            end
            fetched++;
            n_cmp++; if (fetch_hold !== 1'b0) begin n_fail++; $display("FAIL bp_pre%0d: fh got %b want 0", t, fetch_hold); end
        end
        n_cmp++; if (!seen || fetched != 4) begin
            n_fail++; $display("FAIL bp_reach: seen/fetched got %b/%0d want 1/4", seen, fetched); end
        @(negedge clk);
        n_cmp++; if (state !== 2'b11 || bp_hit !== 1'b1) begin
            n_fail++; $display("FAIL bp_capture: st/hit got %b/%b want 11/1", state, bp_hit); end
        drain_and_halt("bp");
        n_cmp++; if (bp_hit !== 1'b1 || pc !== 32'h0040_0010) begin
            n_fail++; $display("FAIL bp_halted: hit/pc got %b/%h want 1/00400010", bp_hit, pc); end
        n_cmp++; if (issue_cnt !== (PERF ? 32'd9 : 32'd0)) begin
            n_fail++; $display("FAIL bp_issue: got %0d want %0d", issue_cnt, PERF ? 9 : 0); end
        run_req = 1'b1;
        wait_state(2'b01, ok);
        run_req = 1'b0;
        n_cmp++; if (!ok || bp_hit !== 1'b0) begin n_fail++; $display("FAIL bp_resume: run/hit got %b/%b want 1/0", ok, bp_hit); end
        wait_pipe(ok);
        n_cmp++; if (!ok || pc !== 32'h0040_0010 || fetch_hold !== 1'b0) begin
            n_fail++; $display("FAIL bp_refetch: tick/pc/fh got %b/%h/%b want 1/00400010/0", ok, pc, fetch_hold); end
        wait_pipe(ok);
        n_cmp++; if (!ok || pc !== 32'h0040_0014 || state !== 2'b01) begin
            n_fail++; $display("FAIL bp_next: tick/pc/st got %b/%h/%b want 1/00400014/01", ok, pc, state); end
        bp_en = 1'b0;
    endtask

    task automatic test_reset_mid_drain;
        bit ok;
        halt_req = 1'b1;
        wait_state(2'b11, ok);
        halt_req = 1'b0;
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rd_enter: st got %b want 11", state); end
        wait_pipe(ok);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== 2'b01 || step_done !== 1'b0 || pipe_en !== 1'b0 || issue_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rd_reset: st/sd/pe/issue got %b/%b/%b/%0d want 01/0/0/0", state, step_done, pipe_en, issue_cnt); end
        test_tick_phase("rd");
    endtask

    task automatic test_div0;
        run_req0 = 1'b1;
        @(negedge clk);
        run_req0 = 1'b0;
        n_cmp++; if (state0 !== 2'b01 || halted0 !== 1'b0 || issue_cnt0 !== 32'd0) begin
            n_fail++; $display("FAIL div0_run: st/hl/issue got %b/%b/%0d want 01/0/0", state0, halted0, issue_cnt0); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (pipe_en0 !== 1'b1 || fetch_hold0 !== 1'b0) begin
                n_fail++; $display("FAIL div0_tick%0d: pe/fh got %b/%b want 1/0", k, pipe_en0, fetch_hold0); end
            @(negedge clk);
        end
        n_cmp++; if (issue_cnt0 !== (PERF ? 32'd4 : 32'd0) || step_done0 !== 1'b0 || bp_hit0 !== 1'b0) begin
            n_fail++; $display("FAIL div0_issue: issue/sd/hit got %0d/%b/%b want %0d/0/0", issue_cnt0, step_done0, bp_hit0, PERF ? 4 : 0); end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        run_req     = 1'b0;
        halt_req    = 1'b0;
        step_req    = 1'b0;
        bp_en       = 1'b0;
        bp_addr     = 32'h0;
        run_req0    = 1'b0;
        pc_load_en  = 1'b1;
        pc_load_val = 32'h0040_0000;
        test_reset;
        pc_load_en  = 1'b0;
        test_tick_phase("run");
        test_halt;
        test_halt_priority;
        test_step;
        test_breakpoint;
        test_reset_mid_drain;
        test_div0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
